// File: rtl/jpeg_enc_zzq_seq_if.sv
// Memory-side bus of the zigzag/quantise sequencer: zigzag index ROM, DCT coefficient RAM,
// fdtbl ROM (all 1-cycle read latency) and the zigzag DU RAM write port.
interface jpeg_enc_zzq_seq_if;
  logic        [5:0]  zzidx_rom_a;
  logic        [5:0]  zzidx_rom_d;
  logic        [5:0]  dctdu_ram_ar;
  logic signed [17:0] dctdu_ram_do;
  logic        [6:0]  fdtbl_rom_a;
  logic        [7:0]  fdtbl_rom_d;
  logic        [5:0]  zzdu_ram_aw;
  logic signed [14:0] zzdu_ram_di;
  logic               zzdu_ram_we;

  modport master (
    output zzidx_rom_a,
    input  zzidx_rom_d,
    output dctdu_ram_ar,
    input  dctdu_ram_do,
    output fdtbl_rom_a,
    input  fdtbl_rom_d,
    output zzdu_ram_aw,
    output zzdu_ram_di,
    output zzdu_ram_we
  );

  modport slave (
    input  zzidx_rom_a,
    output zzidx_rom_d,
    input  dctdu_ram_ar,
    output dctdu_ram_do,
    input  fdtbl_rom_a,
    output fdtbl_rom_d,
    input  zzdu_ram_aw,
    input  zzdu_ram_di,
    input  zzdu_ram_we
  );
endinterface

// File: rtl/jpeg_enc_zzq_seq.sv
// Walks one 8x8 block in zigzag order, multiplies each DCT coefficient by its quant
// reciprocal, rounds/saturates the quotient and writes it to the zigzag DU RAM.
module jpeg_enc_zzq_seq #(
  parameter int SHIFT = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  tbl_sel,
  output logic                  busy,
  output logic                  done,
  jpeg_enc_zzq_seq_if.master    mem
);

  localparam int DATA_W = 18;
  localparam int COEF_W = 8;
  localparam int OUT_W  = 15;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int RND_W  = PROD_W + 1 - SHIFT;

  localparam logic signed [PROD_W:0]  RND    = (PROD_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [RND_W-1:0] SAT_HI = RND_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RND_W-1:0] SAT_LO = -RND_W'(1 << (OUT_W - 1));

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Round half toward +inf: add half an LSB, then the upper bits are the floor.
  function automatic logic signed [RND_W-1:0] round_shift(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W:0] s;
    s = $signed({p[PROD_W-1], p}) + RND;
    return s[PROD_W:SHIFT];
  endfunction

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [RND_W-1:0] v);
    if (v > SAT_HI)      return {1'b0, {(OUT_W-1){1'b1}}};
    else if (v < SAT_LO) return {1'b1, {(OUT_W-1){1'b0}}};
    else                 return v[OUT_W-1:0];
  endfunction

  state_t                    state_q, state_d;
  logic        [5:0]         cnt_q, cnt_d;
  logic                      tbl_sel_q, tbl_sel_d;
  logic                      vld_p1_q, vld_p1_d;
  logic        [5:0]         k_p1_q, k_p1_d;
  logic                      vld_p2_q, vld_p2_d;
  logic        [5:0]         k_p2_q, k_p2_d;
  logic                      we_q, we_d;
  logic        [5:0]         aw_q, aw_d;
  logic signed [OUT_W-1:0]   di_q, di_d;

  logic signed [PROD_W-1:0]  coef_ext, tbl_ext, prod;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tbl_sel_q <= 1'b0;
      vld_p1_q  <= 1'b0;
      k_p1_q    <= '0;
      vld_p2_q  <= 1'b0;
      k_p2_q    <= '0;
      we_q      <= 1'b0;
      aw_q      <= '0;
      di_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tbl_sel_q <= tbl_sel_d;
      vld_p1_q  <= vld_p1_d;
      k_p1_q    <= k_p1_d;
      vld_p2_q  <= vld_p2_d;
      k_p2_q    <= k_p2_d;
      we_q      <= we_d;
      aw_q      <= aw_d;
      di_q      <= di_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tbl_sel_d = tbl_sel_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          tbl_sel_d = tbl_sel;
          cnt_d     = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) state_d = DRAIN;
      end
      DRAIN: begin
        if (!vld_p1_q && !vld_p2_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage 0 -> 1: issue zigzag position k to the index ROM
  always_comb begin
    vld_p1_d = (state_q == RUN);
    k_p1_d   = cnt_q;
    // Stage 1 -> 2: natural index j addresses coefficient RAM and fdtbl ROM
    vld_p2_d = vld_p1_q;
    k_p2_d   = k_p1_q;
  end

  // Stage 2 -> 3: multiply, round, saturate, register the write
  always_comb begin
    coef_ext = PROD_W'(mem.dctdu_ram_do);
    tbl_ext  = PROD_W'($signed({1'b0, mem.fdtbl_rom_d}));
    prod     = coef_ext * tbl_ext;
    we_d     = vld_p2_q;
    aw_d     = aw_q;
    di_d     = di_q;
    if (vld_p2_q) begin
      aw_d = k_p2_q;
      di_d = sat(round_shift(prod));
    end
  end

  assign busy             = (state_q == RUN) || (state_q == DRAIN);
  assign done             = (state_q == DONE);
  assign mem.zzidx_rom_a  = cnt_q;
  assign mem.dctdu_ram_ar = mem.zzidx_rom_d;
  assign mem.fdtbl_rom_a  = {tbl_sel_q, mem.zzidx_rom_d};
  assign mem.zzdu_ram_aw  = aw_q;
  assign mem.zzdu_ram_di  = di_q;
  assign mem.zzdu_ram_we  = we_q;

endmodule

// File: tb/tb_jpeg_enc_zzq_seq.sv
// Bench for jpeg_enc_zzq_seq: memory models plus a scoreboard of expected zzdu writes.
module tb_jpeg_enc_zzq_seq;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic tbl_sel;
  logic busy;
  logic done;

  jpeg_enc_zzq_seq_if bus ();

  jpeg_enc_zzq_seq #(.SHIFT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .tbl_sel (tbl_sel),
    .busy    (busy),
    .done    (done),
    .mem     (bus.master)
  );

  always #5 clk = ~clk;

  logic        [5:0]  zz_rom [64];
  logic signed [17:0] dct_ram [64];
  logic        [7:0]  fd_rom [128];

  always @(posedge clk) begin
    bus.zzidx_rom_d  <= zz_rom[bus.zzidx_rom_a];
    bus.dctdu_ram_do <= dct_ram[bus.dctdu_ram_ar];
    bus.fdtbl_rom_d  <= fd_rom[bus.fdtbl_rom_a];
  end

  typedef struct {int k; int v;} exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int run0  = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int quant(input int c, input int f);
    longint t, q;
    t = longint'(c) * longint'(f) + 128;
    if (t >= 0) q = t / 256;
    else        q = -((-t + 255) / 256);
    if (q > 16383)  q = 16383;
    if (q < -16384) q = -16384;
    return int'(q);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && bus.zzdu_ram_we) begin
      wr_cnt++;
      if (sb.size() == 0) chk("unexpected_we", 1, 0);
      else begin
        e = sb.pop_front();
        chk("aw", int'(bus.zzdu_ram_aw), e.k);
        chk("di", int'(bus.zzdu_ram_di), e.v);
        chk("we_cycle", cyc - run0, e.k + 3);
      end
    end
    if (reset_n && done) begin
      done_cnt++;
      chk("done_cycle", cyc - run0, 67);
      chk("busy_at_done", int'(busy), 0);
    end
  end

  task automatic push_expect(input bit sel);
    for (int k = 0; k < 64; k++)
      sb.push_back('{k, quant(int'(dct_ram[zz_rom[k]]), int'(fd_rom[{sel, zz_rom[k]}]))});
  endtask

  task automatic run_block(input bit sel, input bit spur);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; tbl_sel = sel; run0 = cyc + 1; wr_cnt = 0; done_cnt = 0;
    push_expect(sel);
    for (int n = 0; n < 200 && !seen; n++) begin
      @(posedge clk); #1;
      tbl_sel = ~sel;
      start = spur && ((cyc - run0) == 10 || (cyc - run0) == 66);
      @(negedge clk);
      if ((cyc - run0) == 0)  chk("busy_first", int'(busy), 1);
      if ((cyc - run0) == 5)  chk("tbl_bit", int'(bus.fdtbl_rom_a[6]), int'(sel));
      if ((cyc - run0) == 66) chk("busy_last", int'(busy), 1);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    #1;
    chk("wr_cnt", wr_cnt, 64);
    chk("done_cnt", done_cnt, 1);
    chk("sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_we"},   int'(bus.zzdu_ram_we), 0);
    chk({tag, "_di"},   int'(bus.zzdu_ram_di), 0);
    chk({tag, "_aw"},   int'(bus.zzdu_ram_aw), 0);
    chk({tag, "_za"},   int'(bus.zzidx_rom_a), 0);
  endtask

  int zz_real [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
  int rnd_vals [8] = '{384, -384, 127, 128, -128, -129, 0, 255};

  initial begin
    reset_n = 1'b0; start = 1'b0; tbl_sel = 1'b0;
    for (int i = 0; i < 64; i++) begin
      zz_rom[i]  = 6'(i);
      dct_ram[i] = 18'(i * 256);
    end
    for (int i = 0; i < 128; i++) fd_rom[i] = 8'd1;
    repeat (2) @(posedge clk); #1;
    chk_outputs_zero("reset");
    reset_n = 1'b1;

    // identity zigzag, unit table: zzdu[k] = k
    run_block(1'b0, 1'b0);

    // rounding corner cases, started in the cycle after the previous done
    for (int i = 0; i < 64; i++) dct_ram[i] = 18'(rnd_vals[i % 8]);
    run_block(1'b0, 1'b0);

    // saturation with the largest reciprocal
    for (int i = 0; i < 128; i++) fd_rom[i] = 8'd255;
    for (int i = 0; i < 64; i++)
      dct_ram[i] = (i % 4 == 0) ? 18'sd131071 : (i % 4 == 1) ? -18'sd131072 : 18'($urandom);
    run_block(1'b1, 1'b0);

    // real zigzag, distinct Y / UV tables
    for (int i = 0; i < 64; i++) begin
      zz_rom[i]  = 6'(zz_real[i]);
      dct_ram[i] = 18'sd256;
    end
    for (int i = 0; i < 128; i++) fd_rom[i] = (i < 64) ? 8'd2 : 8'd4;
    run_block(1'b0, 1'b0);
    run_block(1'b1, 1'b0);

    // random data; stray starts at run cycles 10 and 66 must be ignored
    for (int i = 0; i < 64; i++) dct_ram[i] = 18'($urandom);
    for (int i = 0; i < 128; i++) fd_rom[i] = 8'($urandom);
    run_block(1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("idle_wr_cnt", wr_cnt, 64);
    chk("idle_busy", int'(busy), 0);
    run_block(1'b1, 1'b0);

    // reset asserted in run cycle 30
    @(posedge clk); #1;
    start = 1'b1; tbl_sel = 1'b0; run0 = cyc + 1; wr_cnt = 0; done_cnt = 0;
    push_expect(1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    while ((cyc - run0) < 30) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    chk("midrst_wr_cnt", wr_cnt, 27);
    sb.delete();
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1; wr_cnt = 0; done_cnt = 0;
    repeat (20) @(negedge clk);
    chk("post_rst_wr", wr_cnt, 0);
    chk("post_rst_done", done_cnt, 0);
    chk("post_rst_busy", int'(busy), 0);
    run_block(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=%0d exp=%0d", cyc, 0);
    $fatal(1, "watchdog expired");
  end

endmodule
